// File: rtl/cas_pkg.sv
// Shared constants and types for the cassette monitor and overlay.
// Holds the FSM state encoding and the sample-magnitude helper.
package cas_pkg;

    localparam int CAS_POS_W = 25;
    localparam logic [7:0] CAS_SILENCE = 8'h80;
    localparam logic [CAS_POS_W-1:0] CAS_POS_MAX = {CAS_POS_W{1'b1}};
    localparam logic [CAS_POS_W-1:0] CAS_POS_ZERO = {CAS_POS_W{1'b0}};
    localparam logic [CAS_POS_W-1:0] CAS_POS_ONE = {{(CAS_POS_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        CAS_IDLE    = 2'd0,
        CAS_LOADING = 2'd1,
        CAS_READY   = 2'd2
    } cas_state_t;

    // Distance of an unsigned sample from the silence midpoint, 0..127.
    function automatic logic [6:0] cas_mag(input logic [7:0] s);
        logic [7:0] d;
        if (s >= CAS_SILENCE) begin
            d = s - CAS_SILENCE;
        end else begin
            d = 8'd127 - s;
        end
        return d[6:0];
    endfunction

endpackage

// File: rtl/cas_env_follower.sv
// Peak envelope follower: instant attack on louder samples, 1-LSB linear decay
// every DECAY_DIV clocks.
module cas_env_follower
    import cas_pkg::*;
#(
    parameter int DECAY_DIV = 4096,
    parameter int ATTACK_SH = 0
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       motor,
    input  logic       smp_valid,
    input  logic [7:0] smp,
    output logic [7:0] tape_data
);

    localparam int TW = $clog2(DECAY_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(DECAY_DIV - 1);
    localparam logic [TW-1:0] T_ZERO = TW'(0);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    logic [TW-1:0] timer_r;
    logic [7:0]    level_r;
    logic [7:0]    lvl_s;
    logic          attack_s;
    logic          tick_s;

    // Sample level and attack/decay decisions for this cycle.
    always_comb begin
        lvl_s    = {cas_mag(smp), 1'b0} >> ATTACK_SH;
        attack_s = smp_valid && motor && (lvl_s > level_r);
        tick_s   = (timer_r == T_LAST);
    end

    // Envelope level and decay timer; an attack overrides a coincident decay tick.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            timer_r <= T_ZERO;
            level_r <= 8'd0;
        end else if (attack_s) begin
            timer_r <= T_ZERO;
            level_r <= lvl_s;
        end else if (tick_s) begin
            timer_r <= T_ZERO;
            level_r <= (level_r != 8'd0) ? (level_r - 8'd1) : 8'd0;
        end else begin
            timer_r <= timer_r + T_ONE;
            level_r <= level_r;
        end
    end

    assign tape_data = level_r;

endmodule

// File: rtl/cas_tape_monitor.sv
// Tracks tape length, play position and audio envelope for the cassette overlay.
// Load FSM and position counters live here; the envelope is a sub-module.
module cas_tape_monitor
    import cas_pkg::*;
#(
    parameter int DECAY_DIV = 4096,
    parameter int ATTACK_SH = 0
) (
    input  logic                 i_clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 load_byte,
    input  logic                 load_done,
    input  logic                 motor,
    input  logic                 rd_strobe,
    input  logic                 rewind,
    input  logic                 smp_valid,
    input  logic [7:0]           smp,
    output logic [CAS_POS_W-1:0] max,
    output logic [CAS_POS_W-1:0] pos,
    output logic [7:0]           tape_data,
    output logic                 loaded
);

    logic [1:0]           rst_sync_r;
    logic                 rst_s;
    cas_state_t           state_r;
    cas_state_t           next_s;
    logic [CAS_POS_W-1:0] len_cnt_r;
    logic [CAS_POS_W-1:0] len_next_s;
    logic [CAS_POS_W-1:0] max_r;
    logic [CAS_POS_W-1:0] pos_r;
    logic                 loaded_r;
    logic                 done_s;
    logic                 pos_adv_s;

    // Reset asserts immediately but releases two clocks later, on an edge.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end

    assign rst_s = rst_sync_r[1];

    // Next state plus length/position step decisions.
    always_comb begin
        next_s = state_r;
        case (state_r)
            CAS_IDLE:    next_s = load_start ? CAS_LOADING : CAS_IDLE;
            CAS_LOADING: begin
                if (load_start) begin
                    next_s = CAS_LOADING;
                end else if (load_done) begin
                    next_s = CAS_READY;
                end else begin
                    next_s = CAS_LOADING;
                end
            end
            CAS_READY:   next_s = load_start ? CAS_LOADING : CAS_READY;
            default:     next_s = CAS_IDLE;
        endcase
        len_next_s = (load_byte && (len_cnt_r != CAS_POS_MAX)) ? (len_cnt_r + CAS_POS_ONE) : len_cnt_r;
        done_s     = (state_r == CAS_LOADING) && load_done && !load_start;
        pos_adv_s  = rd_strobe && motor && (pos_r < max_r);
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge rst_s) begin
        if (rst_s) begin
            state_r <= CAS_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Length counter; max is only published on a completed load.
    always_ff @(posedge i_clk or posedge rst_s) begin
        if (rst_s) begin
            len_cnt_r <= CAS_POS_ZERO;
            max_r     <= CAS_POS_ZERO;
            loaded_r  <= 1'b0;
        end else if (load_start) begin
            len_cnt_r <= CAS_POS_ZERO;
            max_r     <= max_r;
            loaded_r  <= 1'b0;
        end else if (done_s) begin
            len_cnt_r <= len_next_s;
            max_r     <= len_next_s;
            loaded_r  <= 1'b1;
        end else if (state_r == CAS_LOADING) begin
            len_cnt_r <= len_next_s;
            max_r     <= max_r;
            loaded_r  <= 1'b0;
        end else begin
            len_cnt_r <= len_cnt_r;
            max_r     <= max_r;
            loaded_r  <= loaded_r;
        end
    end

    // Play position: only +1 steps or a jump to zero, so the overlay can count changes.
    always_ff @(posedge i_clk or posedge rst_s) begin
        if (rst_s) begin
            pos_r <= CAS_POS_ZERO;
        end else if (load_start || (state_r != CAS_READY)) begin
            pos_r <= CAS_POS_ZERO;
        end else if (rewind) begin
            pos_r <= CAS_POS_ZERO;
        end else if (pos_adv_s) begin
            pos_r <= pos_r + CAS_POS_ONE;
        end else begin
            pos_r <= pos_r;
        end
    end

    cas_env_follower #(
        .DECAY_DIV (DECAY_DIV),
        .ATTACK_SH (ATTACK_SH)
    ) u_env (
        .i_clk     (i_clk),
        .rst       (rst_s),
        .motor     (motor),
        .smp_valid (smp_valid),
        .smp       (smp),
        .tape_data (tape_data)
    );

    assign max    = max_r;
    assign pos    = pos_r;
    assign loaded = loaded_r;

endmodule

// File: tb/tb_cas_tape_monitor.sv
// Directed bench for cas_tape_monitor: load, play, rewind, motor gating,
// envelope attack/decay and reset during a load.
module tb_cas_tape_monitor;
    import cas_pkg::*;

    logic                 i_clk;
    logic                 reset;
    logic                 load_start;
    logic                 load_byte;
    logic                 load_done;
    logic                 motor;
    logic                 rd_strobe;
    logic                 rewind;
    logic                 smp_valid;
    logic [7:0]           smp;
    logic [CAS_POS_W-1:0] max;
    logic [CAS_POS_W-1:0] pos;
    logic [7:0]           tape_data;
    logic                 loaded;

    int cmp_count = 0;
    int err_count = 0;

    cas_tape_monitor #(.DECAY_DIV(16), .ATTACK_SH(0)) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .load_start (load_start),
        .load_byte  (load_byte),
        .load_done  (load_done),
        .motor      (motor),
        .rd_strobe  (rd_strobe),
        .rewind     (rewind),
        .smp_valid  (smp_valid),
        .smp        (smp),
        .max        (max),
        .pos        (pos),
        .tape_data  (tape_data),
        .loaded     (loaded)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        cmp_count++; if (max !== 25'd0) begin err_count++; $display("FAIL reset_max got %0d want 0", max); end
        cmp_count++; if (pos !== 25'd0) begin err_count++; $display("FAIL reset_pos got %0d want 0", pos); end
        cmp_count++; if (tape_data !== 8'd0) begin err_count++; $display("FAIL reset_env got %0d want 0", tape_data); end
        cmp_count++; if (loaded !== 1'b0) begin err_count++; $display("FAIL reset_loaded got %0b want 0", loaded); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_load;
        load_start = 1'b1; tick(); load_start = 1'b0;
        cmp_count++; if (loaded !== 1'b0) begin err_count++; $display("FAIL load_busy_loaded got %0b want 0", loaded); end
        load_byte = 1'b1; repeat (1000) tick(); load_byte = 1'b0;
        cmp_count++; if (max !== 25'd0) begin err_count++; $display("FAIL load_partial_max got %0d want 0", max); end
        load_done = 1'b1; tick(); load_done = 1'b0;
        cmp_count++; if (max !== 25'd1000) begin err_count++; $display("FAIL load_max got %0d want 1000", max); end
        cmp_count++; if (loaded !== 1'b1) begin err_count++; $display("FAIL load_loaded got %0b want 1", loaded); end
        cmp_count++; if (pos !== 25'd0) begin err_count++; $display("FAIL load_pos got %0d want 0", pos); end
    endtask

    task automatic test_play;
        int exp_pos;
        motor = 1'b1;
        rd_strobe = 1'b1;
        for (int i = 0; i < 1005; i++) begin
            tick();
            exp_pos = (i + 1 > 1000) ? 1000 : i + 1;
            cmp_count++;
            if (pos !== 25'(exp_pos)) begin
                err_count++; $display("FAIL play_step%0d got %0d want %0d", i, pos, exp_pos);
            end
        end
        rd_strobe = 1'b0;
    endtask

    task automatic test_rewind;
        rewind = 1'b1; tick(); rewind = 1'b0;
        cmp_count++; if (pos !== 25'd0) begin err_count++; $display("FAIL rewind_first got %0d want 0", pos); end
        rd_strobe = 1'b1; repeat (37) tick(); rd_strobe = 1'b0;
        cmp_count++; if (pos !== 25'd37) begin err_count++; $display("FAIL rewind_pos37 got %0d want 37", pos); end
        rewind = 1'b1; rd_strobe = 1'b1; tick(); rewind = 1'b0; rd_strobe = 1'b0;
        cmp_count++; if (pos !== 25'd0) begin err_count++; $display("FAIL rewind_priority got %0d want 0", pos); end
        rewind = 1'b1; tick(); rewind = 1'b0; tick();
        cmp_count++; if (pos !== 25'd0) begin err_count++; $display("FAIL rewind_again got %0d want 0", pos); end
    endtask

    task automatic test_motor_off;
        rd_strobe = 1'b1; repeat (5) tick(); rd_strobe = 1'b0;
        motor = 1'b0;
        rd_strobe = 1'b1; repeat (10) tick(); rd_strobe = 1'b0;
        cmp_count++; if (pos !== 25'd5) begin err_count++; $display("FAIL motor_off_pos got %0d want 5", pos); end
        load_done = 1'b1; tick(); load_done = 1'b0;
        cmp_count++; if (max !== 25'd1000) begin err_count++; $display("FAIL stray_done_max got %0d want 1000", max); end
        cmp_count++; if (loaded !== 1'b1) begin err_count++; $display("FAIL stray_done_loaded got %0b want 1", loaded); end
        smp = 8'hFF; smp_valid = 1'b1; tick(); smp_valid = 1'b0;
        cmp_count++; if (tape_data !== 8'd0) begin err_count++; $display("FAIL motor_off_env got %0d want 0", tape_data); end
    endtask

    task automatic test_envelope;
        motor = 1'b1;
        smp = 8'h90; smp_valid = 1'b1; tick(); smp_valid = 1'b0;
        cmp_count++; if (tape_data !== 8'd32) begin err_count++; $display("FAIL env_h90 got %0d want 32", tape_data); end
        smp = 8'h70; smp_valid = 1'b1; tick(); smp_valid = 1'b0;
        cmp_count++; if (tape_data !== 8'd32) begin err_count++; $display("FAIL env_quieter got %0d want 32", tape_data); end
        smp = 8'hFF; smp_valid = 1'b1; tick(); smp_valid = 1'b0;
        cmp_count++; if (tape_data !== 8'd254) begin err_count++; $display("FAIL env_attack got %0d want 254", tape_data); end
        repeat (15) tick();
        cmp_count++; if (tape_data !== 8'd254) begin err_count++; $display("FAIL env_hold15 got %0d want 254", tape_data); end
        tick();
        cmp_count++; if (tape_data !== 8'd253) begin err_count++; $display("FAIL env_decay16 got %0d want 253", tape_data); end
        repeat (254 * 16 - 17) tick();
        cmp_count++; if (tape_data !== 8'd1) begin err_count++; $display("FAIL env_almost got %0d want 1", tape_data); end
        tick();
        cmp_count++; if (tape_data !== 8'd0) begin err_count++; $display("FAIL env_zero got %0d want 0", tape_data); end
        repeat (40) tick();
        cmp_count++; if (tape_data !== 8'd0) begin err_count++; $display("FAIL env_floor got %0d want 0", tape_data); end
        smp = 8'h00; smp_valid = 1'b1; tick(); smp_valid = 1'b0;
        cmp_count++; if (tape_data !== 8'd254) begin err_count++; $display("FAIL env_h00 got %0d want 254", tape_data); end
    endtask

    task automatic test_reset_mid_load;
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_byte = 1'b1; repeat (500) tick(); load_byte = 1'b0;
        reset = 1'b1; #1;
        cmp_count++; if (max !== 25'd0) begin err_count++; $display("FAIL midload_max got %0d want 0", max); end
        cmp_count++; if (loaded !== 1'b0) begin err_count++; $display("FAIL midload_loaded got %0b want 0", loaded); end
        cmp_count++; if (tape_data !== 8'd0) begin err_count++; $display("FAIL midload_env got %0d want 0", tape_data); end
        tick(); reset = 1'b0;
        repeat (4) tick();
        load_done = 1'b1; tick(); load_done = 1'b0;
        cmp_count++; if (loaded !== 1'b0) begin err_count++; $display("FAIL idle_done_loaded got %0b want 0", loaded); end
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_byte = 1'b1; repeat (9) tick();
        load_done = 1'b1; tick(); load_done = 1'b0; load_byte = 1'b0;
        cmp_count++; if (max !== 25'd10) begin err_count++; $display("FAIL reload_max got %0d want 10", max); end
        cmp_count++; if (loaded !== 1'b1) begin err_count++; $display("FAIL reload_loaded got %0b want 1", loaded); end
        rd_strobe = 1'b1; repeat (12) tick(); rd_strobe = 1'b0;
        cmp_count++; if (pos !== 25'd10) begin err_count++; $display("FAIL reload_sat got %0d want 10", pos); end
    endtask

    initial begin
        reset = 1'b0; load_start = 1'b0; load_byte = 1'b0; load_done = 1'b0;
        motor = 1'b0; rd_strobe = 1'b0; rewind = 1'b0; smp_valid = 1'b0; smp = 8'h80;
        #3;
        test_reset();
        test_load();
        test_play();
        test_rewind();
        test_motor_off();
        test_envelope();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
